// File: rtl/rcpu_defs.sv
// rtl/rcpu_defs.sv - shared register-file widths and writeback requester indices
package rcpu_defs;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_MDU  = 2;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int pos;
        pos = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Walk from farthest to nearest so the candidate closest to ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = PTR_W'(pos);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - round-robin write-port arbiter for the RCPU register file
module reg_wb_arbiter
    import rcpu_defs::*;
#(
    parameter int N_REQ = 3,
    parameter int PTR_W = 3
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Wb_Enable,
    input  logic [N_REQ-1:0]              Req_Valid,
    input  logic [REG_ADDR_W*N_REQ-1:0]   Req_Addr,
    input  logic [REG_DATA_W*N_REQ-1:0]   Req_Data,
    output logic [N_REQ-1:0]              Req_Ready,
    input  logic [REG_ADDR_W-1:0]         R_Addr_A,
    input  logic [REG_ADDR_W-1:0]         R_Addr_B,
    output logic [REG_ADDR_W-1:0]         W_Addr,
    output logic [REG_DATA_W-1:0]         W_Data,
    output logic                          Write_Reg,
    output logic                          Hazard_A,
    output logic                          Hazard_B,
    output logic [15:0]                   Drop_Cnt
);

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [REG_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [REG_DATA_W-1:0] w_data_q, w_data_d;
    logic                  write_reg_q, write_reg_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic [N_REQ-1:0]      pick_req;
    logic [N_REQ-1:0]      pick_gnt;
    logic [PTR_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [REG_DATA_W-1:0] sel_data;

    // Gating with Reset keeps Req_Ready low while reset is held, so no grant leaks out.
    assign pick_req = Req_Valid & {N_REQ{Wb_Enable & ~Reset}};

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (pick_req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign Req_Ready = pick_gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = Req_Addr[REG_ADDR_W*i +: REG_ADDR_W];
                sel_data = Req_Data[REG_DATA_W*i +: REG_DATA_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        write_reg_d = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        if (pick_any) begin
            rr_ptr_d    = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            w_addr_d    = sel_addr;
            w_data_d    = sel_data;
            write_reg_d = (sel_addr != REG_ZERO);
            if (sel_addr == REG_ZERO && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr_q    <= '0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            write_reg_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            write_reg_q <= write_reg_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign W_Addr    = w_addr_q;
    assign W_Data    = w_data_q;
    assign Write_Reg = write_reg_q;
    assign Drop_Cnt  = drop_cnt_q;
    assign Hazard_A  = write_reg_q & (w_addr_q == R_Addr_A);
    assign Hazard_B  = write_reg_q & (w_addr_q == R_Addr_B);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    logic        Clk;
    logic        Reset;
    logic        Wb_Enable;
    logic [2:0]  Req_Valid;
    logic [14:0] Req_Addr;
    logic [95:0] Req_Data;
    logic [2:0]  Req_Ready;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;
    logic        Hazard_A;
    logic        Hazard_B;
    logic [15:0] Drop_Cnt;

    int checks;
    int failures;

    reg_wb_arbiter #(.N_REQ(3), .PTR_W(3)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Wb_Enable (Wb_Enable),
        .Req_Valid (Req_Valid),
        .Req_Addr  (Req_Addr),
        .Req_Data  (Req_Data),
        .Req_Ready (Req_Ready),
        .R_Addr_A  (R_Addr_A),
        .R_Addr_B  (R_Addr_B),
        .W_Addr    (W_Addr),
        .W_Data    (W_Data),
        .Write_Reg (Write_Reg),
        .Hazard_A  (Hazard_A),
        .Hazard_B  (Hazard_B),
        .Drop_Cnt  (Drop_Cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        Req_Addr[5*i +: 5]  = a;
        Req_Data[32*i +: 32] = d;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Wb_Enable = 1'b1; Req_Valid = 3'b111;
        Req_Addr = '0; Req_Data = '0; R_Addr_A = '0; R_Addr_B = '0;
        set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2); set_req(2, 5'd3, 32'h3);
        tick(); tick();
        checks++;
        if (Req_Ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", Req_Ready); end
        checks++;
        if (Write_Reg !== 1'b0 || W_Addr !== 5'd0 || W_Data !== 32'd0 || Drop_Cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state got we=%b a=%0d d=%h dc=%0d exp 0", Write_Reg, W_Addr, W_Data, Drop_Cnt);
        end
        checks++;
        if (Hazard_A !== 1'b0 || Hazard_B !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b%b exp=00", Hazard_A, Hazard_B); end
        Req_Valid = 3'b000;
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_req(1, 5'd7, 32'hDEADBEEF);
        Req_Valid = 3'b010;
        #1;
        checks++;
        if (Req_Ready !== 3'b010) begin failures++; $display("FAIL single_ready got=%b exp=010", Req_Ready); end
        tick();
        Req_Valid = 3'b000;
        checks++;
        if (Write_Reg !== 1'b1 || W_Addr !== 5'd7 || W_Data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_write got we=%b a=%0d d=%h exp we=1 a=7 d=deadbeef", Write_Reg, W_Addr, W_Data);
        end
        tick();
        checks++;
        if (Write_Reg !== 1'b0 || W_Addr !== 5'd7) begin failures++; $display("FAIL single_idle got we=%b a=%0d exp we=0 a=7", Write_Reg, W_Addr); end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_rdy;
        int g;
        // pointer sits at 2 after the single write; one grant to requester 2 wraps it to 0
        for (int i = 0; i < 3; i++) set_req(i, 5'(10 + i), 32'hA000_0000 + i);
        Req_Valid = 3'b100;
        tick();
        Req_Valid = 3'b111;
        for (int k = 0; k < 9; k++) begin
            g = k % 3;
            exp_rdy = 3'b001 << g;
            #1;
            checks++;
            if (Req_Ready !== exp_rdy) begin failures++; $display("FAIL fair_ready[%0d] got=%b exp=%b", k, Req_Ready, exp_rdy); end
            tick();
            checks++;
            if (Write_Reg !== 1'b1 || W_Addr !== 5'(10 + g) || W_Data !== 32'hA000_0000 + g) begin
                failures++;
                $display("FAIL fair_write[%0d] got we=%b a=%0d d=%h exp a=%0d", k, Write_Reg, W_Addr, W_Data, 10 + g);
            end
        end
        Req_Valid = 3'b000;
    endtask

    task automatic test_hazard();
        set_req(0, 5'd5, 32'h55);
        Req_Valid = 3'b001;
        R_Addr_A = 5'd5; R_Addr_B = 5'd6;
        tick();
        Req_Valid = 3'b000;
        checks++;
        if (Hazard_A !== 1'b1 || Hazard_B !== 1'b0) begin failures++; $display("FAIL hazard_hit got=%b%b exp=10", Hazard_A, Hazard_B); end
        R_Addr_B = 5'd5;
        #1;
        checks++;
        if (Hazard_B !== 1'b1) begin failures++; $display("FAIL hazard_b_hit got=%b exp=1", Hazard_B); end
        tick();
        checks++;
        if (Hazard_A !== 1'b0 || Hazard_B !== 1'b0) begin failures++; $display("FAIL hazard_clear got=%b%b exp=00", Hazard_A, Hazard_B); end
        R_Addr_A = '0; R_Addr_B = '0;
    endtask

    task automatic test_zero();
        set_req(2, 5'd0, 32'h1234);
        Req_Valid = 3'b100;
        #1;
        checks++;
        if (Req_Ready !== 3'b100) begin failures++; $display("FAIL zero_ready got=%b exp=100", Req_Ready); end
        tick();
        checks++;
        if (Write_Reg !== 1'b0 || Drop_Cnt !== 16'd1) begin
            failures++;
            $display("FAIL zero_drop got we=%b dc=%0d exp we=0 dc=1", Write_Reg, Drop_Cnt);
        end
        for (int k = 0; k < 65534; k++) tick();
        checks++;
        if (Drop_Cnt !== 16'hFFFF) begin failures++; $display("FAIL zero_full got=%h exp=ffff", Drop_Cnt); end
        tick(); tick();
        checks++;
        if (Drop_Cnt !== 16'hFFFF || Write_Reg !== 1'b0) begin
            failures++;
            $display("FAIL zero_saturate got dc=%h we=%b exp dc=ffff we=0", Drop_Cnt, Write_Reg);
        end
        Req_Valid = 3'b000;
        set_req(2, 5'd12, 32'hA000_0002);
        tick();
    endtask

    task automatic test_enable();
        // pointer is 0 after the $0 writes from requester 2
        Req_Valid = 3'b111;
        tick();
        Wb_Enable = 1'b0;
        #1;
        checks++;
        if (Req_Ready !== 3'b000 || Write_Reg !== 1'b1 || W_Addr !== 5'd5) begin
            failures++;
            $display("FAIL enable_drain got rdy=%b we=%b a=%0d exp rdy=000 we=1 a=5", Req_Ready, Write_Reg, W_Addr);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (Req_Ready !== 3'b000 || Write_Reg !== 1'b0) begin
                failures++;
                $display("FAIL enable_off[%0d] got rdy=%b we=%b exp rdy=000 we=0", k, Req_Ready, Write_Reg);
            end
        end
        Wb_Enable = 1'b1;
        #1;
        checks++;
        if (Req_Ready !== 3'b010) begin failures++; $display("FAIL enable_resume got=%b exp=010", Req_Ready); end
        tick();
        checks++;
        if (Write_Reg !== 1'b1 || W_Addr !== 5'd11) begin failures++; $display("FAIL enable_write got we=%b a=%0d exp we=1 a=11", Write_Reg, W_Addr); end
    endtask

    task automatic test_reset_mid();
        // requester 2 is next; its write is in flight when reset hits
        tick();
        checks++;
        if (Write_Reg !== 1'b1 || W_Addr !== 5'd12) begin failures++; $display("FAIL mid_pre got we=%b a=%0d exp we=1 a=12", Write_Reg, W_Addr); end
        R_Addr_A = 5'd12;
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (Write_Reg !== 1'b0 || W_Addr !== 5'd0 || W_Data !== 32'd0 || Drop_Cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset got we=%b a=%0d d=%h dc=%h exp all 0", Write_Reg, W_Addr, W_Data, Drop_Cnt);
        end
        checks++;
        if (Req_Ready !== 3'b000 || Hazard_A !== 1'b0) begin failures++; $display("FAIL mid_reset_comb got rdy=%b hz=%b exp 000/0", Req_Ready, Hazard_A); end
        tick();
        Reset = 1'b0;
        #1;
        checks++;
        if (Req_Ready !== 3'b001) begin failures++; $display("FAIL mid_first_grant got=%b exp=001", Req_Ready); end
        tick();
        checks++;
        if (Write_Reg !== 1'b1 || W_Addr !== 5'd5) begin failures++; $display("FAIL mid_first_write got we=%b a=%0d exp we=1 a=5", Write_Reg, W_Addr); end
        Req_Valid = 3'b000;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_fairness();
        test_hazard();
        test_zero();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port arbiter for the 32×32 register file of the RCPU. It shares the file's single write port (W_Addr / W_Data / Write_Reg) between N_REQ writeback sources (ALU, load unit, multiply/divide) using round-robin arbitration with a valid/ready handshake. Each granted write is held in a registered output stage that drives the register file. The block also reports read-after-write hazards against that in-flight write.

## Interface
Parameters:
- N_REQ, 3, number of writeback requesters (2..8); index 0 = ALU, 1 = load, 2 = mul/div.
- PTR_W, 3, width of the round-robin pointer; must satisfy 2^PTR_W ≥ N_REQ.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  reset, asynchronous, active-high.
- Wb_Enable  in  1  global enable; when low, no grants are issued.
- Req_Valid  in  N_REQ  per-requester write request.
- Req_Addr  in  5*N_REQ  flattened destination register numbers; requester i occupies [5i+4:5i].
- Req_Data  in  32*N_REQ  flattened write data; requester i occupies [32i+31:32i].
- Req_Ready  out  N_REQ  one-hot grant; a transfer happens when Req_Valid[i] and Req_Ready[i] are both high at a rising edge.
- R_Addr_A  in  5  register-file read address A, used for hazard check.
- R_Addr_B  in  5  register-file read address B, used for hazard check.
- W_Addr  out  5  register-file write address.
- W_Data  out  32  register-file write data.
- Write_Reg  out  1  register-file write enable.
- Hazard_A  out  1  R_Addr_A matches the in-flight write.
- Hazard_B  out  1  R_Addr_B matches the in-flight write.
- Drop_Cnt  out  16  count of writes to $0 that were discarded; saturates.

## Operation
- Arbiter state: rr_ptr (PTR_W bits), the first index searched on the next arbitration.
- Grant search: scan rr_ptr, rr_ptr+1, … modulo N_REQ; grant the first i with Req_Valid[i] = 1.
- Req_Ready is combinational: one-hot for the winner, all-zero when Wb_Enable = 0 or no request is valid.
- On a transfer from requester i:
  - rr_ptr ← (i+1) mod N_REQ.
  - Output stage loads W_Addr ← Req_Addr[i] and W_Data ← Req_Data[i].
  - Write_Reg ← 1, unless Req_Addr[i] = 0.
- Writes to $0: the transfer is still acknowledged, but Write_Reg ← 0 and Drop_Cnt increments, saturating at 16'hFFFF.
- No transfer in a cycle: Write_Reg ← 0. W_Addr and W_Data hold their previous values. rr_ptr holds.
- Hazard_A = Write_Reg & (W_Addr == R_Addr_A). Hazard_B is the same using R_Addr_B. Both are combinational.
- Requesters may change Req_Addr / Req_Data while not granted; no stability is required before the grant.
- A requester whose Req_Valid drops in the same cycle it would be granted is simply not granted; there is no penalty.

## Timing
- Reset values: W_Addr = 0, W_Data = 0, Write_Reg = 0, rr_ptr = 0, Drop_Cnt = 0.
  - With Reset high, Req_Ready = 0, Hazard_A = 0, Hazard_B = 0.
- Latency, handshake edge to register-file update:
  - edge T: handshake completes.
  - edge T+1: register file writes (Write_Reg is high during the T→T+1 cycle).
- Throughput: one write per cycle; the output stage is replaced every cycle and never stalls.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once every N_REQ cycles.
- Wb_Enable low: no grants. An in-flight Write_Reg still completes its single cycle, then drops to 0.
- Reset asserted mid-operation: the in-flight write is cancelled (Write_Reg = 0 immediately, asynchronous), rr_ptr returns to 0, and no pending grant survives.
- rr_ptr wrap-around: the increment from N_REQ-1 goes to 0, not to 2^PTR_W-1.

## Structure
- Shared package / header (`rcpu_defs`): REG_ADDR_W = 5, REG_DATA_W = 32, REG_ZERO = 5'd0, and the requester index constants WB_ALU = 0, WB_LOAD = 1, WB_MDU = 2.
- One sub-module, `rr_pick`: a combinational round-robin priority picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-grant flag.
- Everything else (output stage, pointer, Drop_Cnt, hazard compare) lives in reg_wb_arbiter.

## Test plan
- Reset check: assert Reset mid-write with Write_Reg = 1 → Write_Reg, W_Addr, W_Data, Drop_Cnt all 0 immediately. After release, the first grant goes to requester 0.
- Single requester: Req_Valid = 3'b010, Req_Addr[1] = 5'd7, Req_Data[1] = 32'hDEADBEEF → Req_Ready = 3'b010 in the same cycle. The next cycle shows Write_Reg = 1, W_Addr = 7, W_Data = 32'hDEADBEEF.
- Fairness: all three valid continuously for 9 cycles → grant order 0,1,2,0,1,2,0,1,2, each Write_Reg carrying the matching data.
- Zero register: requester 2 writes $0 with 32'h1234 → Req_Ready[2] = 1, Write_Reg stays 0, Drop_Cnt goes 0→1. Force Drop_Cnt = 16'hFFFF, repeat → stays 16'hFFFF.
- Hazard: in-flight write to $5 with R_Addr_A = 5, R_Addr_B = 6 → Hazard_A = 1, Hazard_B = 0. Next cycle with no request → both 0.
- Enable gating: Wb_Enable = 0 with all requests valid for 4 cycles → Req_Ready = 0 and Write_Reg = 0 after the drain cycle. Re-enable → the grant resumes at the saved rr_ptr.
